// File: rtl/mdio_controller.sv
// ---------------------------------------------------------------------------
// mdio_controller
//
// MDIO station-management initiator. A 32-bit management word is accepted
// from the host. The controller generates MDC and sends PREAMBLE_LEN ones,
// then the 32 frame bits (MSB first), on MDIO_OUT. For read opcodes
// (OP = 2'b10) the line is released from the first turnaround bit onwards.
// The 16 responder data bits are shifted in on the MDC rising edges. When
// the frame ends they are presented on RD_DATA together with a one-cycle
// DATA_RDY pulse.
//
// Parameters
//   MDC_HALF      clk cycles per MDC half-period (>= 1)
//   PREAMBLE_LEN  number of preamble ones sent before ST
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   MDIO_START  single-cycle request, accepted only while BUSY = 0
//   T_DATA      transaction word {ST, OP, PHYAD, REGAD, TA, DATA}
//   MDC         management clock toward the responder (idles low)
//   MDIO_OUT    serial data toward the responder
//   MDIO_OE     1 = controller drives MDIO, 0 = released
//   MDIO_IN     serial data from the responder
//   RD_DATA     last captured read data
//   DATA_RDY    one-cycle pulse when a read completes
//   BUSY        transaction in progress
// ---------------------------------------------------------------------------
module mdio_controller #(
  parameter int MDC_HALF     = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  input  logic        MDIO_IN,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  localparam int NBITS = PREAMBLE_LEN + 32;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = $clog2(2 * MDC_HALF);

  // Bit-index landmarks within the complete preamble + frame sequence.
  localparam logic [BW-1:0] PRE_END  = BW'(PREAMBLE_LEN);       // ST bit 0
  localparam logic [BW-1:0] TA_BIT   = BW'(PREAMBLE_LEN + 14);  // first TA bit
  localparam logic [BW-1:0] CAP_BIT  = BW'(PREAMBLE_LEN + 16);  // first data bit
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  // Position inside one MDC period: 0..MDC_HALF-1 low, then high.
  localparam logic [DW-1:0] RISE_AT  = DW'(MDC_HALF - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * MDC_HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    FRAME,
    READ_CAPTURE,
    DONE
  } state_t;

  state_t          state_reg,   state_next;
  logic [DW-1:0]   div_reg,     div_next;
  logic [BW-1:0]   bit_reg,     bit_next;
  logic [31:0]     tx_reg,      tx_next;
  logic [15:0]     rx_reg,      rx_next;
  logic            is_read_reg, is_read_next;
  logic            mdc_reg,     mdc_next;
  logic            out_reg,     out_next;
  logic            oe_reg,      oe_next;
  logic [15:0]     rd_data_reg, rd_data_next;
  logic            rdy_reg,     rdy_next;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      bit_reg     <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      is_read_reg <= 1'b0;
      mdc_reg     <= 1'b0;
      out_reg     <= 1'b0;
      oe_reg      <= 1'b0;
      rd_data_reg <= '0;
      rdy_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      bit_reg     <= bit_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      is_read_reg <= is_read_next;
      mdc_reg     <= mdc_next;
      out_reg     <= out_next;
      oe_reg      <= oe_next;
      rd_data_reg <= rd_data_next;
      rdy_reg     <= rdy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    bit_next     = bit_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    is_read_next = is_read_reg;
    mdc_next     = mdc_reg;
    out_next     = out_reg;
    oe_next      = oe_reg;
    rd_data_next = rd_data_reg;
    rdy_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (MDIO_START) begin
          state_next   = (PREAMBLE_LEN > 0) ? PREAMBLE : FRAME;
          tx_next      = T_DATA;
          rx_next      = '0;
          is_read_next = (T_DATA[29:28] == 2'b10);
          div_next     = '0;
          bit_next     = '0;
          mdc_next     = 1'b0;
          oe_next      = 1'b1;
          out_next     = (PREAMBLE_LEN > 0) ? 1'b1 : T_DATA[31];
        end
      end

      PREAMBLE, FRAME, READ_CAPTURE: begin
        if (div_reg == DIV_LAST) begin
          // End of the high phase: MDC falls, and the next bit (or the
          // idle condition) is presented in the same cycle.
          div_next = '0;
          mdc_next = 1'b0;
          if (bit_reg == LAST_BIT) begin
            state_next = DONE;
            oe_next    = 1'b0;
            out_next   = 1'b0;
            if (is_read_reg) begin
              rd_data_next = rx_reg;
              rdy_next     = 1'b1;
            end
          end else begin
            bit_next = bit_reg + BW'(1);
            // tx_reg[31] always holds the current frame bit once the
            // preamble is over; shift only when leaving a frame bit.
            if (bit_reg >= PRE_END) begin
              tx_next = {tx_reg[30:0], 1'b0};
            end
            if (is_read_reg && (bit_next >= TA_BIT)) begin
              state_next = READ_CAPTURE;
              oe_next    = 1'b0;
              out_next   = 1'b0;
            end else begin
              state_next = (bit_next < PRE_END) ? PREAMBLE : FRAME;
              oe_next    = 1'b1;
              out_next   = (bit_next < PRE_END) ? 1'b1 : tx_next[31];
            end
          end
        end else begin
          div_next = div_reg + DW'(1);
          if (div_reg == RISE_AT) begin
            mdc_next = 1'b1;
            // Responder data is sampled on the same edge that raises MDC;
            // the second TA bit is not captured.
            if ((state_reg == READ_CAPTURE) && (bit_reg >= CAP_BIT)) begin
              rx_next = {rx_reg[14:0], MDIO_IN};
            end
          end
        end
      end

      // One cycle with BUSY low before a new request can be taken.
      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign MDC      = mdc_reg;
  assign MDIO_OUT = out_reg;
  assign MDIO_OE  = oe_reg;
  assign RD_DATA  = rd_data_reg;
  assign DATA_RDY = rdy_reg;
  assign BUSY     = (state_reg == PREAMBLE) || (state_reg == FRAME) ||
                    (state_reg == READ_CAPTURE);

endmodule
